// File: rtl/register_tree_pq_pkg.sv
// rtl/register_tree_pq_pkg.sv - shared types and helpers for the register heap priority queue
package register_tree_pq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INSERT,
        ST_SIFT
    } pq_state_e;

    // Heap level of a node index: floor(log2(idx + 1)).
    function automatic int unsigned heap_level(input int unsigned idx);
        int unsigned lvl;
        lvl = 0;
        for (int unsigned b = 1; b < 32; b++) begin
            if (((idx + 1) >> b) != 0) begin
                lvl = b;
            end
        end
        return lvl;
    endfunction

endpackage

// File: rtl/pq_cmp_swap.sv
// rtl/pq_cmp_swap.sv - unsigned max/min of two keys with an a-greater-than-b flag
module pq_cmp_swap #(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] max_val,
    output logic [DATA_WIDTH-1:0] min_val,
    output logic                  a_gt_b
);

    assign a_gt_b  = (a > b);
    assign max_val = a_gt_b ? a : b;
    assign min_val = a_gt_b ? b : a;

endmodule

// File: rtl/register_tree_pq.sv
// rtl/register_tree_pq.sv - max-priority queue as a flip-flop binary heap with one level per cycle
module register_tree_pq
    import register_tree_pq_pkg::*;
#(
    parameter bit ENQ_ENA    = 1'b1,
    parameter int QUEUE_SIZE = 15,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  i_CLK,
    input  logic                  i_RSTn,
    input  logic                  i_wrt,
    input  logic                  i_read,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DATA_WIDTH-1:0] o_data
);

    localparam int SW = $clog2(QUEUE_SIZE + 1);
    localparam int IW = (QUEUE_SIZE > 1) ? $clog2(QUEUE_SIZE) : 1;
    localparam int XW = IW + 2;
    localparam int D  = $clog2(QUEUE_SIZE + 1) - 1;
    localparam int LW = (D > 0) ? $clog2(D + 1) : 1;

    logic [QUEUE_SIZE-1:0][DATA_WIDTH-1:0] queue, next_queue;
    logic [SW-1:0]         size, next_size;
    pq_state_e             state, next_state;
    logic [DATA_WIDTH-1:0] carry, next_carry;
    logic [IW-1:0]         idx, next_idx;
    logic [LW-1:0]         level, next_level;
    logic [LW-1:0]         ins_depth, next_depth;

    logic is_full, is_empty;
    logic req_rep, req_enq, req_deq;

    assign is_full  = (size == SW'(QUEUE_SIZE));
    assign is_empty = (size == '0);
    assign o_full   = is_full;
    assign o_empty  = is_empty;
    assign o_data   = queue[0];

    // Replace on an empty queue is an insert of the single key, whatever ENQ_ENA says.
    assign req_rep = i_wrt & i_read;
    assign req_enq = (i_wrt & ~i_read & ENQ_ENA & ~is_full) | (req_rep & is_empty);
    assign req_deq = i_read & ~i_wrt & ~is_empty;

    logic [DATA_WIDTH-1:0] acc_max, acc_min;
    logic                  acc_gt;

    pq_cmp_swap #(.DATA_WIDTH(DATA_WIDTH)) u_acc (
        .a       (i_data),
        .b       (queue[0]),
        .max_val (acc_max),
        .min_val (acc_min),
        .a_gt_b  (acc_gt)
    );

    // Insert walks the ancestors of the target slot t: at level l the node is ((t+1) >> (depth(t)-l)) - 1.
    logic [SW-1:0]         tgt_plus1;
    logic [IW-1:0]         path_idx;
    logic [DATA_WIDTH-1:0] ins_max, ins_min;
    logic                  ins_gt;

    assign tgt_plus1 = SW'(idx) + 1'b1;
    assign path_idx  = IW'((tgt_plus1 >> (ins_depth - level)) - 1'b1);

    pq_cmp_swap #(.DATA_WIDTH(DATA_WIDTH)) u_ins (
        .a       (carry),
        .b       (queue[path_idx]),
        .max_val (ins_max),
        .min_val (ins_min),
        .a_gt_b  (ins_gt)
    );

    logic [XW-1:0]         lc_w, rc_w, best_lc_w;
    logic                  l_valid, r_valid;
    logic [DATA_WIDTH-1:0] l_val, r_val;
    logic [DATA_WIDTH-1:0] kid_max, kid_min;
    logic                  kid_gt;
    logic [IW-1:0]         best_idx;
    logic [DATA_WIDTH-1:0] sift_max, sift_min;
    logic                  sift_gt;
    logic                  do_swap;

    assign lc_w    = {1'b0, idx, 1'b1};
    assign rc_w    = lc_w + 1'b1;
    assign l_valid = (lc_w < XW'(size));
    assign r_valid = (rc_w < XW'(size));
    assign l_val   = l_valid ? queue[IW'(lc_w)] : '0;
    assign r_val   = r_valid ? queue[IW'(rc_w)] : '0;

    // Ties between children go left; a missing right child reads as 0 and never wins.
    pq_cmp_swap #(.DATA_WIDTH(DATA_WIDTH)) u_kid (
        .a       (r_val),
        .b       (l_val),
        .max_val (kid_max),
        .min_val (kid_min),
        .a_gt_b  (kid_gt)
    );

    assign best_idx  = (r_valid && kid_gt) ? IW'(rc_w) : IW'(lc_w);
    assign best_lc_w = {1'b0, best_idx, 1'b1};

    pq_cmp_swap #(.DATA_WIDTH(DATA_WIDTH)) u_sift (
        .a       (kid_max),
        .b       (queue[idx]),
        .max_val (sift_max),
        .min_val (sift_min),
        .a_gt_b  (sift_gt)
    );

    assign do_swap = l_valid & sift_gt;

    logic unused_cmp;
    assign unused_cmp = ^{acc_gt, ins_gt, kid_min, sift_max, sift_min};

    always_comb begin
        next_queue = queue;
        next_size  = size;
        next_state = state;
        next_carry = carry;
        next_idx   = idx;
        next_level = level;
        next_depth = ins_depth;
        case (state)
            ST_IDLE: begin
                if (req_enq) begin
                    next_queue[0] = acc_max;
                    next_carry    = acc_min;
                    next_size     = size + 1'b1;
                    next_idx      = IW'(size);
                    next_depth    = LW'(heap_level(32'(size)));
                    next_level    = LW'(1);
                    if (heap_level(32'(size)) != 0) begin
                        next_state = ST_INSERT;
                    end
                end else if (req_deq) begin
                    // With a single element the clear overrides the root copy and the queue empties.
                    next_queue[0]                   = queue[IW'(size - 1'b1)];
                    next_queue[IW'(size - 1'b1)]    = '0;
                    next_size                       = size - 1'b1;
                    next_idx                        = '0;
                    if (size > SW'(2)) begin
                        next_state = ST_SIFT;
                    end
                end else if (req_rep) begin
                    next_queue[0] = i_data;
                    next_idx      = '0;
                    if (size > SW'(1)) begin
                        next_state = ST_SIFT;
                    end
                end
            end
            ST_INSERT: begin
                next_queue[path_idx] = ins_max;
                next_carry           = ins_min;
                next_level           = level + 1'b1;
                if (level == ins_depth) begin
                    next_state = ST_IDLE;
                end
            end
            ST_SIFT: begin
                if (do_swap) begin
                    next_queue[idx]      = kid_max;
                    next_queue[best_idx] = queue[idx];
                    next_idx             = best_idx;
                    if (best_lc_w >= XW'(size)) begin
                        next_state = ST_IDLE;
                    end
                end else begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_RSTn) begin
            queue     <= '0;
            size      <= '0;
            state     <= ST_IDLE;
            carry     <= '0;
            idx       <= '0;
            level     <= '0;
            ins_depth <= '0;
        end else begin
            queue     <= next_queue;
            size      <= next_size;
            state     <= next_state;
            carry     <= next_carry;
            idx       <= next_idx;
            level     <= next_level;
            ins_depth <= next_depth;
        end
    end

endmodule

// File: tb/tb_register_tree_pq.sv
// tb/tb_register_tree_pq.sv - directed and randomized checks of register_tree_pq against a multiset model
module tb_register_tree_pq;

    localparam int N = 15;
    localparam int W = 16;
    localparam int D = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_a, wrt_a, read_a, full_a, empty_a;
    logic [W-1:0] data_a, odata_a;
    logic         rst_b, wrt_b, read_b, full_b, empty_b;
    logic [W-1:0] data_b, odata_b;

    register_tree_pq #(.ENQ_ENA(1'b1), .QUEUE_SIZE(N), .DATA_WIDTH(W)) dut (
        .i_CLK   (clk),
        .i_RSTn  (rst_a),
        .i_wrt   (wrt_a),
        .i_read  (read_a),
        .i_data  (data_a),
        .o_full  (full_a),
        .o_empty (empty_a),
        .o_data  (odata_a)
    );

    register_tree_pq #(.ENQ_ENA(1'b0), .QUEUE_SIZE(N), .DATA_WIDTH(W)) dut_ne (
        .i_CLK   (clk),
        .i_RSTn  (rst_b),
        .i_wrt   (wrt_b),
        .i_read  (read_b),
        .i_data  (data_b),
        .o_full  (full_b),
        .o_empty (empty_b),
        .o_data  (odata_b)
    );

    int checks   = 0;
    int failures = 0;
    int mq[2][$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model_max(input int k);
        int m = 0;
        for (int i = 0; i < mq[k].size(); i++) begin
            if (mq[k][i] > m) m = mq[k][i];
        end
        return m;
    endfunction

    function automatic void model_del_max(input int k);
        int at = 0;
        for (int i = 1; i < mq[k].size(); i++) begin
            if (mq[k][i] > mq[k][at]) at = i;
        end
        mq[k].delete(at);
    endfunction

    function automatic void model_apply(input int k, input bit w, input bit r, input int d);
        bit enq_ena = (k == 0);
        if (w && r) begin
            if (mq[k].size() > 0) model_del_max(k);
            mq[k].push_back(d);
        end else if (w) begin
            if (enq_ena && mq[k].size() < N) mq[k].push_back(d);
        end else if (r) begin
            if (mq[k].size() > 0) model_del_max(k);
        end
    endfunction

    task automatic drive(input int k, input bit w, input bit r, input int d);
        @(negedge clk);
        if (k == 0) begin
            wrt_a = w; read_a = r; data_a = W'(d);
        end else begin
            wrt_b = w; read_b = r; data_b = W'(d);
        end
        @(negedge clk);
        if (k == 0) begin
            wrt_a = 1'b0; read_a = 1'b0;
        end else begin
            wrt_b = 1'b0; read_b = 1'b0;
        end
        model_apply(k, w, r, d);
    endtask

    task automatic op(input int k, input bit w, input bit r, input int d);
        drive(k, w, r, d);
        repeat (D + 1) @(negedge clk);
    endtask

    task automatic do_reset(input int k);
        @(negedge clk);
        if (k == 0) rst_a = 1'b1; else rst_b = 1'b1;
        @(negedge clk);
        if (k == 0) rst_a = 1'b0; else rst_b = 1'b0;
        mq[k].delete();
    endtask

    task automatic check_state(input int k, input string tag);
        int n = mq[k].size();
        if (k == 0) begin
            check({tag, ":data"},  odata_a, model_max(0));
            check({tag, ":empty"}, empty_a, n == 0);
            check({tag, ":full"},  full_a,  n == N);
            check({tag, ":size"},  dut.size, n);
        end else begin
            check({tag, ":data"},  odata_b, model_max(1));
            check({tag, ":empty"}, empty_b, n == 0);
            check({tag, ":full"},  full_b,  n == N);
            check({tag, ":size"},  dut_ne.size, n);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fill[15]   = '{5, 900, 17, 300, 1024, 0, 44, 600, 2, 99, 750, 12, 8, 450, 1};
        int deq_exp[7] = '{900, 750, 600, 450, 300, 99, 44};
        logic [N-1:0][W-1:0] pre;

        rst_a = 1'b1; wrt_a = 1'b0; read_a = 1'b0; data_a = '0;
        rst_b = 1'b1; wrt_b = 1'b0; read_b = 1'b0; data_b = '0;
        repeat (2) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;

        check("reset:data_a",  odata_a, 0);
        check("reset:empty_a", empty_a, 1);
        check("reset:full_a",  full_a,  0);
        check("reset:data_b",  odata_b, 0);
        check("reset:empty_b", empty_b, 1);

        for (int i = 0; i < 15; i++) begin
            op(0, 1'b1, 1'b0, fill[i]);
            check_state(0, "fill");
        end
        check("fill:full",  full_a,  1);
        check("fill:empty", empty_a, 0);
        check("fill:data",  odata_a, 1024);

        op(0, 1'b1, 1'b0, 1000);
        check("enq_full:data", odata_a, 1024);
        check("enq_full:size", dut.size, 15);
        check("enq_full:full", full_a, 1);

        for (int i = 0; i < 7; i++) begin
            op(0, 1'b0, 1'b1, 0);
            check("deq_order", odata_a, deq_exp[i]);
            check_state(0, "deq");
        end
        for (int i = 0; i < 9; i++) begin
            op(0, 1'b0, 1'b1, 0);
            check_state(0, "deq_rest");
        end
        check("drain:empty", empty_a, 1);
        check("drain:data",  odata_a, 0);
        check("drain:size",  dut.size, 0);

        // Second request lands while the insert of 10 is still in flight and must be dropped.
        op(0, 1'b1, 1'b0, 5);
        @(negedge clk);
        wrt_a = 1'b1; data_a = 16'd10;
        @(negedge clk);
        data_a = 16'd20;
        @(negedge clk);
        wrt_a = 1'b0;
        mq[0].push_back(10);
        repeat (D + 1) @(negedge clk);
        check("busy_ignore:size", dut.size, 2);
        check("busy_ignore:data", odata_a, 10);

        do_reset(0);
        for (int i = 0; i < 15; i++) op(0, 1'b1, 1'b0, fill[i]);
        op(0, 1'b1, 1'b1, 1000);
        check("rep_big:data", odata_a, 1000);
        check("rep_big:size", dut.size, 15);
        op(0, 1'b1, 1'b1, 3);
        check("rep_small:data", odata_a, 900);
        check_state(0, "rep_small");

        for (int i = 0; i < 300; i++) begin
            int sel = $urandom_range(0, 9);
            int key = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 65535);
            if (sel < 5)      op(0, 1'b1, 1'b0, key);
            else if (sel < 8) op(0, 1'b0, 1'b1, 0);
            else              op(0, 1'b1, 1'b1, key);
            check_state(0, "rand");
        end

        while (mq[0].size() < N) op(0, 1'b1, 1'b0, $urandom_range(1, 65535));
        drive(0, 1'b0, 1'b1, 0);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        mq[0].delete();
        check("rst_mid:nodes", dut.queue == '0, 1);
        check("rst_mid:empty", empty_a, 1);
        check("rst_mid:data",  odata_a, 0);

        for (int i = 0; i < N; i++) pre[i] = W'((N - i) * 100);
        @(negedge clk);
        force dut_ne.next_queue = pre;
        force dut_ne.next_size  = 4'(N);
        @(posedge clk);
        #1;
        release dut_ne.next_queue;
        release dut_ne.next_size;
        for (int i = 0; i < N; i++) mq[1].push_back((N - i) * 100);
        @(negedge clk);
        check("preload:full", full_b, 1);
        check_state(1, "preload");

        for (int i = 0; i < 7; i++) begin
            op(1, 1'b0, 1'b1, 0);
            check_state(1, "ne_deq");
        end
        for (int i = 0; i < 7; i++) begin
            op(1, 1'b1, 1'b0, 5000 + i);
            check("ne_enq:data", odata_b, 800);
            check("ne_enq:size", dut_ne.size, 8);
        end
        check("ne_enq:full",  full_b,  0);
        check("ne_enq:empty", empty_b, 0);

        op(1, 1'b1, 1'b1, 60000);
        check("ne_rep:data", odata_b, 60000);
        check_state(1, "ne_rep");

        for (int i = 0; i < 8; i++) op(1, 1'b0, 1'b1, 0);
        check("ne_drain:empty", empty_b, 1);
        op(1, 1'b1, 1'b1, 77);
        check("ne_rep_empty:data", odata_b, 77);
        check("ne_rep_empty:size", dut_ne.size, 1);
        check_state(1, "ne_rep_empty");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
